matrix_count_directory: RTL

Per-dimension bookkeeping table that sits directly upstream of the matrix info display and the matrix store datapath. It holds the number of stored matrices for every (rows, cols) pair from 1..MAX_SIZE. It answers the display's registered (qry_row, qry_col) -> qry_cnt lookup. It also hands the storage writer a slot index on each new matrix, overwriting round-robin once a dimension is full.

---
 rtl/matrix_count_directory.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/matrix_count_directory.sv
// Per-dimension matrix count table.
// Tracks how many matrices are stored for each (rows, cols) pair, hands out
// storage slots (round-robin overwrite once a dimension is full) and serves a
// free-running one-cycle count lookup for the display.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | waiting for clear_req (priority) or alloc_req
//  LOOKUP  | latched dimension checked; legal -> entry read, illegal -> err
//  COMMIT  | slot handed out, count or round-robin pointer updated, ack
//  CLEAR   | one entry zeroed per cycle; total cleared after the last one
module matrix_count_directory #(
    parameter int MAX_SIZE     = 5,
    parameter int CNT_WIDTH    = 5,
    parameter int MAX_PER_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    input  logic [2:0]           alloc_row,
    input  logic [2:0]           alloc_col,
    output logic                 alloc_ack,
    output logic                 alloc_err,
    output logic [CNT_WIDTH-1:0] alloc_slot,
    input  logic                 clear_req,
    output logic                 busy,
    input  logic [2:0]           qry_row,
    input  logic [2:0]           qry_col,
    output logic [CNT_WIDTH-1:0] qry_cnt,
    output logic [7:0]           total_cnt
);

    localparam int N_ENTRIES = MAX_SIZE * MAX_SIZE;
    localparam int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    localparam logic [2:0]           MAX_DIM  = 3'(MAX_SIZE);
    localparam logic [CNT_WIDTH-1:0] MAX_PS   = CNT_WIDTH'(MAX_PER_SIZE);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMMIT,
        S_CLEAR
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt_tab [N_ENTRIES];
    logic [CNT_WIDTH-1:0] ptr_tab [N_ENTRIES];
    logic [2:0]           lat_row;
    logic [2:0]           lat_col;
    logic [IDX_W-1:0]     lat_idx;
    logic [IDX_W-1:0]     sweep_idx;
    logic [CNT_WIDTH-1:0] cur_cnt;
    logic [CNT_WIDTH-1:0] cur_ptr;

    logic [IDX_W-1:0]     lat_idx_c;
    logic [IDX_W-1:0]     qry_idx_c;
    logic                 lat_legal;
    logic                 qry_legal;
    logic [CNT_WIDTH-1:0] ptr_nxt;

    function automatic logic dim_legal(input logic [2:0] r, input logic [2:0] c);
        return (r != 3'd0) && (r <= MAX_DIM) && (c != 3'd0) && (c <= MAX_DIM);
    endfunction

    // Only meaningful for legal dimensions; callers guard with dim_legal.
    function automatic logic [IDX_W-1:0] dim_idx(input logic [2:0] r, input logic [2:0] c);
        int t;
        t = (int'(r) - 1) * MAX_SIZE + (int'(c) - 1);
        return IDX_W'(t);
    endfunction

    assign lat_legal = dim_legal(lat_row, lat_col);
    assign lat_idx_c = dim_idx(lat_row, lat_col);
    assign qry_legal = dim_legal(qry_row, qry_col);
    assign qry_idx_c = dim_idx(qry_row, qry_col);
    assign ptr_nxt   = cur_ptr + CNT_WIDTH'(1);

    // Sequencing FSM: owns the table, the round-robin pointers and all handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            alloc_ack  <= 1'b0;
            alloc_err  <= 1'b0;
            alloc_slot <= '0;
            total_cnt  <= '0;
            lat_row    <= '0;
            lat_col    <= '0;
            lat_idx    <= '0;
            sweep_idx  <= '0;
            cur_cnt    <= '0;
            cur_ptr    <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                cnt_tab[i] <= '0;
                ptr_tab[i] <= '0;
            end
        end else begin
            alloc_ack <= 1'b0;
            alloc_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A clear wins; a simultaneous alloc is dropped without a response.
                    if (clear_req) begin
                        state     <= S_CLEAR;
                        sweep_idx <= '0;
                        busy      <= 1'b1;
                    end else if (alloc_req) begin
                        lat_row <= alloc_row;
                        lat_col <= alloc_col;
                        state   <= S_LOOKUP;
                        busy    <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (!lat_legal) begin
                        alloc_err <= 1'b1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        lat_idx <= lat_idx_c;
                        cur_cnt <= cnt_tab[lat_idx_c];
                        cur_ptr <= ptr_tab[lat_idx_c];
                        state   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    alloc_ack <= 1'b1;
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    if (cur_cnt < MAX_PS) begin
                        alloc_slot       <= cur_cnt;
                        cnt_tab[lat_idx] <= cur_cnt + CNT_WIDTH'(1);
                        total_cnt        <= total_cnt + 8'd1;
                    end else begin
                        // Full: overwrite the oldest slot and move the pointer on.
                        alloc_slot       <= cur_ptr;
                        ptr_tab[lat_idx] <= (ptr_nxt == MAX_PS) ? '0 : ptr_nxt;
                    end
                end
                S_CLEAR: begin
                    cnt_tab[sweep_idx] <= '0;
                    ptr_tab[sweep_idx] <= '0;
                    if (sweep_idx == LAST_IDX) begin
                        total_cnt <= '0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        sweep_idx <= sweep_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running registered lookup; forced to zero while the table is being wiped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qry_cnt <= '0;
        end else if (state == S_CLEAR) begin
            qry_cnt <= '0;
        end else if (qry_legal) begin
            qry_cnt <= cnt_tab[qry_idx_c];
        end else begin
            qry_cnt <= '0;
        end
    end

endmodule
